// File: rtl/kv_pkg.sv
// rtl/kv_pkg.sv - shared types and default widths for the keyvalue arbiter
package kv_pkg;

    localparam int KV_AW      = 16;
    localparam int KV_DW      = 16;
    localparam int KV_TIMEOUT = 64;
    localparam int KV_CNTW    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } kv_state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } kv_port_t;

    typedef struct packed {
        logic              we;
        logic              adr_key;
        logic              dat_key;
        logic [KV_AW-1:0]  adr;
        logic [KV_DW-1:0]  dat;
    } kv_req_t;

endpackage

// File: rtl/keyvalue_arbiter_if.sv
// rtl/keyvalue_arbiter_if.sv - one requester's bus into the keyvalue arbiter
interface keyvalue_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          stb_i;
    logic          we_i;
    logic          adr_key_i;
    logic          dat_key_i;
    logic [AW-1:0] adr_i;
    logic [DW-1:0] dat_i;
    logic          ack_o;
    logic [DW-1:0] dat_o;
    logic          dup_o;
    logic          err_o;

    // Directions are named from the arbiter's point of view.
    modport slave (
        input  stb_i, we_i, adr_key_i, dat_key_i, adr_i, dat_i,
        output ack_o, dat_o, dup_o, err_o
    );

    modport master (
        output stb_i, we_i, adr_key_i, dat_key_i, adr_i, dat_i,
        input  ack_o, dat_o, dup_o, err_o
    );
endinterface

// File: rtl/kv_rr_arb2.sv
// rtl/kv_rr_arb2.sv - two-way round-robin arbiter with registered last-grant pointer
module kv_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt
);
    // High when A won the last grant, so B is preferred on the next tie.
    logic last_a_q;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_a_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_a_q <= 1'b0;
        end else if (grant_en && (|gnt)) begin
            last_a_q <= gnt[0];
        end
    end
endmodule

// File: rtl/keyvalue_arbiter.sv
// rtl/keyvalue_arbiter.sv - shares one keyvalue store core between two requesters
module keyvalue_arbiter
    import kv_pkg::*;
#(
    parameter int AW      = KV_AW,
    parameter int DW      = KV_DW,
    parameter int TIMEOUT = KV_TIMEOUT,
    parameter int CNTW    = KV_CNTW
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    keyvalue_arbiter_if.slave   a,
    keyvalue_arbiter_if.slave   b,
    output logic                kv_stb_o,
    output logic                kv_cyc_o,
    output logic                kv_we_o,
    output logic                kv_adr_key_o,
    output logic                kv_dat_key_o,
    output logic [AW-1:0]       kv_adr_o,
    output logic [DW-1:0]       kv_dat_o,
    input  logic                kv_ack_i,
    input  logic [DW-1:0]       kv_dat_i,
    input  logic                kv_dup_i,
    output logic [3*CNTW-1:0]   stat_o
);
    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    kv_state_t       state_q, state_d;
    kv_port_t        winner_q;
    kv_req_t         req_q, a_req, b_req;
    logic            stb_q;
    logic [WDW-1:0]  wdog_q;
    logic [DW-1:0]   a_dat_q, b_dat_q;
    logic            dup_q, err_q;
    logic [CNTW-1:0] a_grants_q, b_grants_q, timeouts_q;
    logic [1:0]      gnt;
    logic            grant_en, ack_hit, timeout_hit, resp;

    assign a_req = '{we: a.we_i, adr_key: a.adr_key_i, dat_key: a.dat_key_i,
                     adr: a.adr_i, dat: a.dat_i};
    assign b_req = '{we: b.we_i, adr_key: b.adr_key_i, dat_key: b.dat_key_i,
                     adr: b.adr_i, dat: b.dat_i};

    kv_rr_arb2 u_arb (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .req      ({b.stb_i, a.stb_i}),
        .grant_en (grant_en),
        .gnt      (gnt)
    );

    always_comb begin
        state_d     = state_q;
        grant_en    = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (a.stb_i || b.stb_i) begin
                    grant_en = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // A store ack in the final watchdog cycle still counts as success.
                if (kv_ack_i) begin
                    ack_hit = 1'b1;
                    state_d = RESP;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            winner_q   <= REQ_A;
            req_q      <= '0;
            stb_q      <= 1'b0;
            wdog_q     <= '0;
            a_dat_q    <= '0;
            b_dat_q    <= '0;
            dup_q      <= 1'b0;
            err_q      <= 1'b0;
            a_grants_q <= '0;
            b_grants_q <= '0;
            timeouts_q <= '0;
        end else begin
            state_q <= state_d;

            if (grant_en) begin
                if (gnt[1]) begin
                    winner_q   <= REQ_B;
                    req_q      <= b_req;
                    b_grants_q <= (&b_grants_q) ? b_grants_q : b_grants_q + 1'b1;
                end else begin
                    winner_q   <= REQ_A;
                    req_q      <= a_req;
                    a_grants_q <= (&a_grants_q) ? a_grants_q : a_grants_q + 1'b1;
                end
            end

            if (state_q == ISSUE) begin
                stb_q  <= 1'b1;
                wdog_q <= '0;
            end else if (state_q == WAIT) begin
                wdog_q <= wdog_q + 1'b1;
            end

            if (ack_hit) begin
                stb_q <= 1'b0;
                dup_q <= kv_dup_i;
                err_q <= 1'b0;
                if (winner_q == REQ_B) begin
                    b_dat_q <= kv_dat_i;
                end else begin
                    a_dat_q <= kv_dat_i;
                end
            end

            // Abort keeps the requester's previous read data intact.
            if (timeout_hit) begin
                stb_q      <= 1'b0;
                dup_q      <= 1'b0;
                err_q      <= 1'b1;
                timeouts_q <= (&timeouts_q) ? timeouts_q : timeouts_q + 1'b1;
            end
        end
    end

    assign resp    = (state_q == RESP);
    assign a.ack_o = resp && (winner_q == REQ_A);
    assign b.ack_o = resp && (winner_q == REQ_B);
    assign a.err_o = a.ack_o && err_q;
    assign b.err_o = b.ack_o && err_q;
    assign a.dup_o = a.ack_o && dup_q;
    assign b.dup_o = b.ack_o && dup_q;
    assign a.dat_o = a_dat_q;
    assign b.dat_o = b_dat_q;

    assign kv_stb_o     = stb_q;
    assign kv_cyc_o     = stb_q;
    assign kv_we_o      = req_q.we;
    assign kv_adr_key_o = req_q.adr_key;
    assign kv_dat_key_o = req_q.dat_key;
    assign kv_adr_o     = req_q.adr;
    assign kv_dat_o     = req_q.dat;

    assign stat_o = {timeouts_q, b_grants_q, a_grants_q};
endmodule

// File: tb/tb_keyvalue_arbiter.sv
// tb/tb_keyvalue_arbiter.sv - directed self-checking bench for keyvalue_arbiter
module tb_keyvalue_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        kv_stb, kv_cyc, kv_we, kv_adr_key, kv_dat_key;
    logic [15:0] kv_adr, kv_dat;
    logic        kv_ack;
    logic [15:0] kv_rdat;
    logic        kv_dup;
    logic [23:0] stat;

    int vectors     = 0;
    int miscompares = 0;

    keyvalue_arbiter_if #(.AW(16), .DW(16)) a_bus ();
    keyvalue_arbiter_if #(.AW(16), .DW(16)) b_bus ();

    keyvalue_arbiter dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .a            (a_bus),
        .b            (b_bus),
        .kv_stb_o     (kv_stb),
        .kv_cyc_o     (kv_cyc),
        .kv_we_o      (kv_we),
        .kv_adr_key_o (kv_adr_key),
        .kv_dat_key_o (kv_dat_key),
        .kv_adr_o     (kv_adr),
        .kv_dat_o     (kv_dat),
        .kv_ack_i     (kv_ack),
        .kv_dat_i     (kv_rdat),
        .kv_dup_i     (kv_dup),
        .stat_o       (stat)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_kv_stb(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!kv_stb && n < 50);
        check(tag, 32'(kv_stb), 32'd1);
    endtask

    task automatic store_ack(input int lat, input logic [15:0] dat, input logic dup);
        repeat (lat) @(negedge clk);
        kv_rdat = dat;
        kv_dup  = dup;
        kv_ack  = 1'b1;
        @(negedge clk);
        kv_ack  = 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        kv_ack = 1'b0; kv_rdat = '0; kv_dup = 1'b0;
        a_bus.stb_i = 0; a_bus.we_i = 0; a_bus.adr_key_i = 0; a_bus.dat_key_i = 0;
        a_bus.adr_i = '0; a_bus.dat_i = '0;
        b_bus.stb_i = 0; b_bus.we_i = 0; b_bus.adr_key_i = 0; b_bus.dat_key_i = 0;
        b_bus.adr_i = '0; b_bus.dat_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_kv_stb", 32'(kv_stb), 32'd0);
        check("rst_kv_cyc", 32'(kv_cyc), 32'd0);
        check("rst_a_ack", 32'(a_bus.ack_o), 32'd0);
        check("rst_b_ack", 32'(b_bus.ack_o), 32'd0);
        check("rst_a_err", 32'(a_bus.err_o), 32'd0);
        check("rst_a_dup", 32'(a_bus.dup_o), 32'd0);
        check("rst_a_dat", 32'(a_bus.dat_o), 32'd0);
        check("rst_b_dat", 32'(b_bus.dat_o), 32'd0);
        check("rst_kv_adr", 32'(kv_adr), 32'd0);
        check("rst_kv_dat", 32'(kv_dat), 32'd0);
        check("rst_stat", 32'(stat), 32'd0);

        // Test 1: A write, store acks three cycles into the strobe
        a_bus.stb_i = 1; a_bus.we_i = 1; a_bus.adr_key_i = 1;
        a_bus.adr_i = 16'h0012; a_bus.dat_i = 16'hBEEF;
        @(negedge clk);
        check("t1_stb_issue", 32'(kv_stb), 32'd0);
        @(negedge clk);
        check("t1_stb_wait", 32'(kv_stb), 32'd1);
        check("t1_cyc_wait", 32'(kv_cyc), 32'd1);
        check("t1_kv_adr", 32'(kv_adr), 32'h0012);
        check("t1_kv_dat", 32'(kv_dat), 32'hBEEF);
        check("t1_kv_we", 32'(kv_we), 32'd1);
        check("t1_kv_adr_key", 32'(kv_adr_key), 32'd1);
        check("t1_kv_dat_key", 32'(kv_dat_key), 32'd0);
        store_ack(2, 16'h5555, 1'b0);
        check("t1_a_ack", 32'(a_bus.ack_o), 32'd1);
        check("t1_b_ack", 32'(b_bus.ack_o), 32'd0);
        check("t1_a_err", 32'(a_bus.err_o), 32'd0);
        check("t1_stb_drop", 32'(kv_stb), 32'd0);
        a_bus.stb_i = 0;
        @(negedge clk);
        check("t1_a_ack_pulse", 32'(a_bus.ack_o), 32'd0);
        check("t1_b_ack_never", 32'(b_bus.ack_o), 32'd0);
        check("t1_stat", 32'(stat), 32'h000001);

        // Test 2: fresh pointer, both request continuously for six rounds
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a_bus.we_i = 0; a_bus.adr_key_i = 0; a_bus.adr_i = 16'h00A0;
        b_bus.adr_i = 16'h00B0;
        a_bus.stb_i = 1; b_bus.stb_i = 1;
        for (int r = 0; r < 6; r++) begin
            wait_kv_stb($sformatf("t2_stb_r%0d", r));
            check($sformatf("t2_adr_r%0d", r), 32'(kv_adr), (r % 2 == 0) ? 32'h00A0 : 32'h00B0);
            store_ack(1, 16'(16'h1000 + r), 1'b0);
            check($sformatf("t2_a_ack_r%0d", r), 32'(a_bus.ack_o), 32'(r % 2 == 0));
            check($sformatf("t2_b_ack_r%0d", r), 32'(b_bus.ack_o), 32'(r % 2 == 1));
        end
        a_bus.stb_i = 0; b_bus.stb_i = 0;
        @(negedge clk);
        check("t2_stat", 32'(stat), 32'h000303);
        check("t2_a_dat", 32'(a_bus.dat_o), 32'h1004);
        check("t2_b_dat", 32'(b_bus.dat_o), 32'h1005);

        // Test 3: B lookup returning duplicate flag
        b_bus.stb_i = 1; b_bus.we_i = 0; b_bus.adr_key_i = 1; b_bus.adr_i = 16'h0077;
        wait_kv_stb("t3_stb");
        check("t3_kv_we", 32'(kv_we), 32'd0);
        check("t3_kv_adr", 32'(kv_adr), 32'h0077);
        store_ack(2, 16'h1234, 1'b1);
        check("t3_b_ack", 32'(b_bus.ack_o), 32'd1);
        check("t3_b_dat", 32'(b_bus.dat_o), 32'h1234);
        check("t3_b_dup", 32'(b_bus.dup_o), 32'd1);
        check("t3_a_ack", 32'(a_bus.ack_o), 32'd0);
        check("t3_a_dat", 32'(a_bus.dat_o), 32'h1004);
        b_bus.stb_i = 0;
        @(negedge clk);
        check("t3_b_ack_pulse", 32'(b_bus.ack_o), 32'd0);
        check("t3_b_dat_held", 32'(b_bus.dat_o), 32'h1234);

        // Test 4: store never acks; watchdog aborts after 64 strobe cycles
        a_bus.stb_i = 1; a_bus.adr_i = 16'h0040;
        wait_kv_stb("t4_stb");
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!kv_stb) break;
            cnt++;
        end
        check("t4_stb_cycles", 32'(cnt), 32'd64);
        check("t4_a_ack", 32'(a_bus.ack_o), 32'd1);
        check("t4_a_err", 32'(a_bus.err_o), 32'd1);
        check("t4_a_dat", 32'(a_bus.dat_o), 32'h1004);
        check("t4_stat", 32'(stat), 32'h010404);
        a_bus.stb_i = 0;
        @(negedge clk);
        check("t4_a_err_clear", 32'(a_bus.err_o), 32'd0);
        check("t4_a_ack_pulse", 32'(a_bus.ack_o), 32'd0);

        // Test 5: reset while waiting on the store
        a_bus.stb_i = 1; a_bus.adr_i = 16'h0055;
        wait_kv_stb("t5_stb");
        rst = 1'b1;
        @(negedge clk);
        check("t5_kv_stb", 32'(kv_stb), 32'd0);
        check("t5_kv_cyc", 32'(kv_cyc), 32'd0);
        check("t5_a_ack", 32'(a_bus.ack_o), 32'd0);
        check("t5_b_ack", 32'(b_bus.ack_o), 32'd0);
        check("t5_stat", 32'(stat), 32'd0);
        a_bus.stb_i = 0;
        rst = 1'b0;
        @(negedge clk);
        check("t5_no_ack", 32'(a_bus.ack_o), 32'd0);
        a_bus.stb_i = 1; a_bus.adr_i = 16'h0099;
        wait_kv_stb("t5_retry_stb");
        store_ack(0, 16'h0099, 1'b0);
        check("t5_retry_ack", 32'(a_bus.ack_o), 32'd1);
        check("t5_retry_dat", 32'(a_bus.dat_o), 32'h0099);
        check("t5_retry_stat", 32'(stat), 32'h000001);
        a_bus.stb_i = 0;
        @(negedge clk);

        // Test 6: request fields change mid-transaction; stray ack in IDLE
        a_bus.stb_i = 1; a_bus.adr_i = 16'h00C0;
        wait_kv_stb("t6_stb");
        a_bus.adr_i = 16'h0DEF;
        a_bus.dat_i = 16'h7777;
        @(negedge clk);
        check("t6_kv_adr_hold", 32'(kv_adr), 32'h00C0);
        store_ack(0, 16'h4321, 1'b0);
        check("t6_a_ack", 32'(a_bus.ack_o), 32'd1);
        check("t6_kv_adr_resp", 32'(kv_adr), 32'h00C0);
        a_bus.stb_i = 0;
        @(negedge clk);
        kv_ack = 1'b1;
        @(negedge clk);
        kv_ack = 1'b0;
        check("t6_late_a_ack", 32'(a_bus.ack_o), 32'd0);
        check("t6_late_b_ack", 32'(b_bus.ack_o), 32'd0);
        check("t6_late_err", 32'(a_bus.err_o), 32'd0);
        check("t6_late_stb", 32'(kv_stb), 32'd0);
        check("t6_a_dat", 32'(a_bus.dat_o), 32'h4321);
        @(negedge clk);
        check("t6_idle_a_ack", 32'(a_bus.ack_o), 32'd0);
        check("t6_stat", 32'(stat), 32'h000002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
